// File: rtl/rob_commit_ctrl_if.sv
// rtl/rob_commit_ctrl_if.sv - issue, result-bus, query and retire signal bundle of the reorder buffer
interface rob_commit_ctrl_if #(
    parameter int ROB_POS_W = 4
);
    logic                 issue;
    logic [1:0]           issue_type;
    logic [4:0]           issue_rd;
    logic [31:0]          issue_pc;
    logic                 issue_pred_jump;
    logic [ROB_POS_W-1:0] issue_rob_pos;
    logic                 rob_full;

    logic                 alu_valid;
    logic [ROB_POS_W-1:0] alu_rob_pos;
    logic [31:0]          alu_val;
    logic                 alu_jump;
    logic [31:0]          alu_target;

    logic                 lsb_valid;
    logic [ROB_POS_W-1:0] lsb_rob_pos;
    logic [31:0]          lsb_val;

    logic [ROB_POS_W-1:0] q1_pos;
    logic [ROB_POS_W-1:0] q2_pos;
    logic                 q1_ready;
    logic                 q2_ready;
    logic [31:0]          q1_val;
    logic [31:0]          q2_val;

    logic                 commit;
    logic [4:0]           commit_rd;
    logic [31:0]          commit_val;
    logic [ROB_POS_W-1:0] commit_rob_pos;
    logic                 commit_store;
    logic                 rollback;
    logic [31:0]          rollback_pc;

    // Core side: decoder, execution units and register file
    modport master (
        output issue, issue_type, issue_rd, issue_pc, issue_pred_jump,
        input  issue_rob_pos, rob_full,
        output alu_valid, alu_rob_pos, alu_val, alu_jump, alu_target,
        output lsb_valid, lsb_rob_pos, lsb_val,
        output q1_pos, q2_pos,
        input  q1_ready, q2_ready, q1_val, q2_val,
        input  commit, commit_rd, commit_val, commit_rob_pos, commit_store,
        input  rollback, rollback_pc
    );

    // Reorder buffer side
    modport slave (
        input  issue, issue_type, issue_rd, issue_pc, issue_pred_jump,
        output issue_rob_pos, rob_full,
        input  alu_valid, alu_rob_pos, alu_val, alu_jump, alu_target,
        input  lsb_valid, lsb_rob_pos, lsb_val,
        input  q1_pos, q2_pos,
        output q1_ready, q2_ready, q1_val, q2_val,
        output commit, commit_rd, commit_val, commit_rob_pos, commit_store,
        output rollback, rollback_pc
    );
endinterface

// File: rtl/rob_commit_ctrl.sv
// rtl/rob_commit_ctrl.sv - reorder buffer: tag allocation, result collection, in-order retire and mispredict flush
module rob_commit_ctrl #(
    parameter int ROB_SIZE  = 16,
    parameter int ROB_POS_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    rob_commit_ctrl_if.slave  rob_if
);
    localparam logic [ROB_POS_W:0] FULL_CNT = (ROB_POS_W+1)'(ROB_SIZE);

    logic                 busy_q   [ROB_SIZE];
    logic                 ready_q  [ROB_SIZE];
    logic [1:0]           type_q   [ROB_SIZE];
    logic [4:0]           rd_q     [ROB_SIZE];
    logic [31:0]          val_q    [ROB_SIZE];
    logic [31:0]          pc_q     [ROB_SIZE];
    logic                 pred_q   [ROB_SIZE];
    logic                 real_q   [ROB_SIZE];
    logic [31:0]          target_q [ROB_SIZE];

    logic [ROB_POS_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [ROB_POS_W:0]   count_q, count_d;
    logic                 commit_q, commit_d;
    logic                 store_q, store_d;
    logic                 rollback_q, rollback_d;
    logic [4:0]           commit_rd_q, commit_rd_d;
    logic [31:0]          commit_val_q, commit_val_d;
    logic [ROB_POS_W-1:0] commit_pos_q, commit_pos_d;
    logic [31:0]          rollback_pc_q, rollback_pc_d;

    logic issue_take, retire, alu_wb, lsb_wb, mispredict;

    assign rob_if.rob_full       = (count_q == FULL_CNT);
    assign rob_if.issue_rob_pos  = tail_q;
    assign rob_if.commit         = commit_q;
    assign rob_if.commit_store   = store_q;
    assign rob_if.rollback       = rollback_q;
    assign rob_if.commit_rd      = commit_rd_q;
    assign rob_if.commit_val     = commit_val_q;
    assign rob_if.commit_rob_pos = commit_pos_q;
    assign rob_if.rollback_pc    = rollback_pc_q;

    // While a flush is pending nothing new enters, completes or retires
    assign issue_take = rob_if.issue && !rob_if.rob_full && !rollback_q;
    assign retire     = busy_q[head_q] && ready_q[head_q] && !rollback_q;
    assign alu_wb     = rob_if.alu_valid && busy_q[rob_if.alu_rob_pos] && !rollback_q;
    assign lsb_wb     = rob_if.lsb_valid && busy_q[rob_if.lsb_rob_pos] && !rollback_q;
    assign mispredict = (real_q[head_q] != pred_q[head_q]);

    // Operand forwarding: a same-cycle result bus hit wins over the stored value
    always_comb begin
        rob_if.q1_ready = ready_q[rob_if.q1_pos];
        rob_if.q1_val   = val_q[rob_if.q1_pos];
        rob_if.q2_ready = ready_q[rob_if.q2_pos];
        rob_if.q2_val   = val_q[rob_if.q2_pos];
        if (rob_if.alu_valid && rob_if.alu_rob_pos == rob_if.q1_pos) begin
            rob_if.q1_ready = 1'b1;
            rob_if.q1_val   = rob_if.alu_val;
        end else if (rob_if.lsb_valid && rob_if.lsb_rob_pos == rob_if.q1_pos) begin
            rob_if.q1_ready = 1'b1;
            rob_if.q1_val   = rob_if.lsb_val;
        end
        if (rob_if.alu_valid && rob_if.alu_rob_pos == rob_if.q2_pos) begin
            rob_if.q2_ready = 1'b1;
            rob_if.q2_val   = rob_if.alu_val;
        end else if (rob_if.lsb_valid && rob_if.lsb_rob_pos == rob_if.q2_pos) begin
            rob_if.q2_ready = 1'b1;
            rob_if.q2_val   = rob_if.lsb_val;
        end
    end

    // Next pointers and retire outputs; pulses default low every cycle
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        commit_d      = 1'b0;
        store_d       = 1'b0;
        rollback_d    = 1'b0;
        commit_rd_d   = commit_rd_q;
        commit_val_d  = commit_val_q;
        commit_pos_d  = commit_pos_q;
        rollback_pc_d = rollback_pc_q;
        if (rollback_q) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (issue_take) tail_d = tail_q + 1'b1;
            if (retire)     head_d = head_q + 1'b1;
            count_d = count_q + (ROB_POS_W+1)'(issue_take) - (ROB_POS_W+1)'(retire);
            if (retire) begin
                commit_pos_d = head_q;
                case (type_q[head_q])
                    2'd1: store_d = 1'b1;
                    2'd2: begin
                        commit_d      = (rd_q[head_q] != 5'd0);
                        commit_rd_d   = rd_q[head_q];
                        commit_val_d  = val_q[head_q];
                        rollback_d    = mispredict;
                        rollback_pc_d = real_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
                    end
                    default: begin
                        commit_d     = (rd_q[head_q] != 5'd0);
                        commit_rd_d  = rd_q[head_q];
                        commit_val_d = val_q[head_q];
                    end
                endcase
            end
        end
    end

    // Pointer and output registers; rdy low only drops the pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_q      <= 1'b0;
            store_q       <= 1'b0;
            rollback_q    <= 1'b0;
            commit_rd_q   <= '0;
            commit_val_q  <= '0;
            commit_pos_q  <= '0;
            rollback_pc_q <= '0;
        end else if (!rdy) begin
            commit_q   <= 1'b0;
            store_q    <= 1'b0;
            rollback_q <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_q      <= commit_d;
            store_q       <= store_d;
            rollback_q    <= rollback_d;
            commit_rd_q   <= commit_rd_d;
            commit_val_q  <= commit_val_d;
            commit_pos_q  <= commit_pos_d;
            rollback_pc_q <= rollback_pc_d;
        end
    end

    // Entry storage: issue fills the tail, result buses fill by tag, retire frees the head
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
            end
        end else if (rdy) begin
            if (rollback_q) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    busy_q[i]  <= 1'b0;
                    ready_q[i] <= 1'b0;
                end
            end else begin
                if (alu_wb) begin
                    ready_q[rob_if.alu_rob_pos]  <= 1'b1;
                    val_q[rob_if.alu_rob_pos]    <= rob_if.alu_val;
                    real_q[rob_if.alu_rob_pos]   <= rob_if.alu_jump;
                    target_q[rob_if.alu_rob_pos] <= rob_if.alu_target;
                end
                if (lsb_wb) begin
                    ready_q[rob_if.lsb_rob_pos] <= 1'b1;
                    val_q[rob_if.lsb_rob_pos]   <= rob_if.lsb_val;
                end
                if (retire) busy_q[head_q] <= 1'b0;
                if (issue_take) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    type_q[tail_q]  <= rob_if.issue_type;
                    rd_q[tail_q]    <= rob_if.issue_rd;
                    pc_q[tail_q]    <= rob_if.issue_pc;
                    pred_q[tail_q]  <= rob_if.issue_pred_jump;
                end
            end
        end
    end
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb/tb_rob_commit_ctrl.sv - randomized check of rob_commit_ctrl against a program-order queue model
module tb_rob_commit_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    rob_commit_ctrl_if #(.ROB_POS_W(4)) rif ();

    rob_commit_ctrl #(.ROB_SIZE(16), .ROB_POS_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .rdy    (rdy),
        .rob_if (rif)
    );

    typedef struct {
        int          tag;
        int          typ;
        int          rd;
        logic [31:0] pc;
        bit          pred;
        bit          done;
        logic [31:0] val;
        bit          rj;
        logic [31:0] tgt;
    } ent_t;

    ent_t rob[$];
    int   head_tag;

    bit          e_commit, e_store, e_rb, e_reset;
    logic [31:0] e_rd, e_val, e_pos, e_pc;

    int tests_run    = 0;
    int tests_failed = 0;

    int p_issue, p_wb, p_br, p_rdylow, p_rst;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int find(input int tag);
        for (int i = 0; i < rob.size(); i++)
            if (rob[i].tag == tag) return i;
        return -1;
    endfunction

    task automatic check_query(input string nm, input int pos, input logic r, input logic [31:0] v);
        int i;
        if (rif.alu_valid && int'(rif.alu_rob_pos) == pos) begin
            check_eq({nm, "_ready_alu"}, 32'(r), 32'd1);
            check_eq({nm, "_val_alu"}, v, rif.alu_val);
        end else if (rif.lsb_valid && int'(rif.lsb_rob_pos) == pos) begin
            check_eq({nm, "_ready_lsb"}, 32'(r), 32'd1);
            check_eq({nm, "_val_lsb"}, v, rif.lsb_val);
        end else begin
            i = find(pos);
            if (i >= 0) begin
                check_eq({nm, "_ready"}, 32'(r), 32'(rob[i].done));
                if (rob[i].done) check_eq({nm, "_val"}, v, rob[i].val);
            end
        end
    endtask

    task automatic drive(input bit force_rst, input bit quiet);
        int cand[$];
        int k, tg, t;
        rst = force_rst || ($urandom % 1000 < p_rst);
        rdy = !($urandom % 100 < p_rdylow);
        rif.issue = !quiet && ($urandom % 100 < p_issue);
        t = $urandom % 100;
        rif.issue_type = (t < p_br) ? 2'd2 : ((t < p_br + 20) ? 2'd1 : 2'd0);
        rif.issue_rd = ($urandom % 5 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rif.issue_pc = $urandom & 32'hffff_fffc;
        rif.issue_pred_jump = 1'($urandom % 2);
        rif.alu_valid = 1'b0;
        rif.lsb_valid = 1'b0;
        rif.alu_rob_pos = 4'($urandom);
        rif.lsb_rob_pos = 4'($urandom);
        rif.alu_val = $urandom;
        rif.alu_jump = 1'($urandom % 2);
        rif.alu_target = $urandom & 32'hffff_fffc;
        rif.lsb_val = $urandom;
        foreach (rob[i]) if (!rob[i].done) cand.push_back(rob[i].tag);
        if (!quiet) begin
            for (int n = 0; n < 2; n++) begin
                if (cand.size() > 0 && $urandom % 100 < p_wb) begin
                    k  = $urandom % cand.size();
                    tg = cand[k];
                    if (!rif.alu_valid && (rob[find(tg)].typ == 2 || $urandom % 2 == 0)) begin
                        rif.alu_valid = 1'b1;
                        rif.alu_rob_pos = 4'(tg);
                        cand.delete(k);
                    end else if (!rif.lsb_valid && rob[find(tg)].typ != 2) begin
                        rif.lsb_valid = 1'b1;
                        rif.lsb_rob_pos = 4'(tg);
                        cand.delete(k);
                    end
                end
            end
            if (!rif.alu_valid && $urandom % 100 < 3) begin
                rif.alu_valid = 1'b1;
                rif.alu_rob_pos = 4'($urandom);
                if (rif.lsb_valid && rif.alu_rob_pos == rif.lsb_rob_pos)
                    rif.alu_rob_pos = rif.lsb_rob_pos + 4'd1;
            end
        end
        rif.q1_pos = (rif.alu_valid && $urandom % 3 == 0) ? rif.alu_rob_pos : 4'($urandom);
        rif.q2_pos = (rif.lsb_valid && $urandom % 3 == 0) ? rif.lsb_rob_pos : 4'($urandom);
    endtask

    task automatic model_step();
        int   tail;
        bit   full;
        int   i;
        ent_t e;
        tail = (head_tag + rob.size()) % 16;
        full = (rob.size() == 16);
        e_reset = 1'b0;
        if (rst) begin
            rob.delete();
            head_tag = 0;
            e_commit = 0; e_store = 0; e_rb = 0; e_reset = 1'b1;
            e_rd = 0; e_val = 0; e_pos = 0; e_pc = 0;
        end else if (!rdy) begin
            e_commit = 0; e_store = 0; e_rb = 0;
        end else if (e_rb) begin
            rob.delete();
            head_tag = 0;
            e_commit = 0; e_store = 0; e_rb = 0;
        end else begin
            e_commit = 0; e_store = 0;
            if (rob.size() > 0 && rob[0].done) begin
                e = rob.pop_front();
                head_tag = (head_tag + 1) % 16;
                e_pos = e.tag;
                if (e.typ == 1) begin
                    e_store = 1;
                end else begin
                    e_commit = (e.rd != 0);
                    e_rd = e.rd;
                    e_val = e.val;
                    if (e.typ == 2) begin
                        e_rb = (e.rj != e.pred);
                        e_pc = e.rj ? e.tgt : e.pc + 32'd4;
                    end
                end
            end
            if (rif.alu_valid) begin
                i = find(int'(rif.alu_rob_pos));
                if (i >= 0) begin
                    rob[i].done = 1; rob[i].val = rif.alu_val;
                    rob[i].rj = rif.alu_jump; rob[i].tgt = rif.alu_target;
                end
            end
            if (rif.lsb_valid) begin
                i = find(int'(rif.lsb_rob_pos));
                if (i >= 0) begin
                    rob[i].done = 1; rob[i].val = rif.lsb_val;
                end
            end
            if (rif.issue && !full) begin
                e.tag = tail; e.typ = int'(rif.issue_type); e.rd = int'(rif.issue_rd);
                e.pc = rif.issue_pc; e.pred = rif.issue_pred_jump; e.done = 0;
                e.val = 0; e.rj = 0; e.tgt = 0;
                rob.push_back(e);
            end
        end
    endtask

    task automatic cycle(input bit force_rst, input bit quiet);
        @(negedge clk);
        drive(force_rst, quiet);
        #1;
        check_eq("rob_full", 32'(rif.rob_full), 32'(rob.size() == 16));
        check_eq("issue_rob_pos", 32'(rif.issue_rob_pos), 32'((head_tag + rob.size()) % 16));
        check_query("q1", int'(rif.q1_pos), rif.q1_ready, rif.q1_val);
        check_query("q2", int'(rif.q2_pos), rif.q2_ready, rif.q2_val);
        model_step();
        @(posedge clk);
        #1;
        check_eq("commit", 32'(rif.commit), 32'(e_commit));
        check_eq("commit_store", 32'(rif.commit_store), 32'(e_store));
        check_eq("rollback", 32'(rif.rollback), 32'(e_rb));
        if (e_commit || e_store || e_reset) check_eq("commit_rob_pos", 32'(rif.commit_rob_pos), e_pos);
        if (e_commit || e_reset) begin
            check_eq("commit_rd", 32'(rif.commit_rd), e_rd);
            check_eq("commit_val", rif.commit_val, e_val);
        end
        if (e_rb || e_reset) check_eq("rollback_pc", rif.rollback_pc, e_pc);
    endtask

    initial begin
        head_tag = 0;
        e_commit = 0; e_store = 0; e_rb = 0; e_reset = 0;
        e_rd = 0; e_val = 0; e_pos = 0; e_pc = 0;
        rst = 1'b1;
        rdy = 1'b1;
        p_issue = 0; p_wb = 0; p_br = 0; p_rdylow = 0; p_rst = 0;
        drive(1'b1, 1'b1);

        for (int c = 0; c < 2; c++) cycle(1'b1, 1'b1);
        for (int c = 0; c < 10; c++) cycle(1'b0, 1'b1);

        // fill up: many issues, rare results, no branches
        p_issue = 90; p_wb = 6; p_br = 0;
        for (int c = 0; c < 400; c++) cycle(1'b0, 1'b0);

        // balanced traffic with branches and stalls
        p_issue = 60; p_wb = 50; p_br = 20; p_rdylow = 8;
        for (int c = 0; c < 1200; c++) cycle(1'b0, 1'b0);

        // branch heavy, occasional reset
        p_issue = 70; p_wb = 70; p_br = 45; p_rdylow = 5; p_rst = 4;
        for (int c = 0; c < 1000; c++) cycle(1'b0, 1'b0);

        // near-full with fast completion
        p_issue = 95; p_wb = 30; p_br = 10; p_rdylow = 0; p_rst = 0;
        for (int c = 0; c < 400; c++) cycle(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
